// File: rtl/apb_mem_slave.sv
// APB4 memory-mapped slave: word-addressed storage with byte-strobe writes,
// a configurable number of wait states, and PSLVERR reporting for
// out-of-range, misaligned and read-only-region accesses.
//
// Handshake: a transfer starts with a setup cycle (PSEL_i=1 while IDLE) that
// captures the address, direction and error status. The access phase then
// runs with PENABLE_i=1 until PREADY_o rises. PREADY_o is only ever high in
// ACCESS with PSEL_i & PENABLE_i and the wait counter exhausted. Dropping
// PSEL_i during ACCESS abandons the transfer without side effects. Write data
// and strobes are sampled on the completion edge only.
module apb_mem_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 0,
  parameter int RO_WORDS    = 0
) (
  input  logic                    PCLK,
  input  logic                    PPRESETn,
  input  logic                    PSEL_i,
  input  logic                    PENABLE_i,
  input  logic                    PWRITE_i,
  input  logic [ADDR_WIDTH-1:0]   PADDR_i,
  input  logic [DATA_WIDTH-1:0]   PWDATA_i,
  input  logic [DATA_WIDTH/8-1:0] PSTRB_i,
  output logic                    PREADY_o,
  output logic [DATA_WIDTH-1:0]   PRDATA_o,
  output logic                    PSLVERR_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFS   = $clog2(BYTES);
  localparam int IW    = $clog2(MEM_DEPTH);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Current FSM state; kept as a named signal so checkers can bind to it.
  state_t state;
  state_t state_next;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Decode of the live address during the setup cycle.
  logic [ADDR_WIDTH-1:0] idx;
  logic                  range_err;
  logic                  align_err;
  logic                  ro_err;
  logic                  req_err;
  logic [IW-1:0]         idx_lo;

  // Transfer context captured at setup.
  logic [IW-1:0]         idx_q;
  logic                  write_q;
  logic                  err_q;
  logic [3:0]            cnt;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic setup;
  logic ready;
  logic wait_step;
  logic do_write;

  // Word index is formed at full address width so that high address bits
  // beyond the memory size are caught as out-of-range instead of aliasing.
  assign idx       = PADDR_i >> OFS;
  assign idx_lo    = idx[IW-1:0];
  assign range_err = (idx >= ADDR_WIDTH'(MEM_DEPTH));
  // Mask form works for byte-wide buses too, where no offset bits exist.
  assign align_err = ((PADDR_i & ADDR_WIDTH'(BYTES - 1)) != '0);

  generate
    if (RO_WORDS > 0) begin : g_ro
      assign ro_err = PWRITE_i & (idx < ADDR_WIDTH'(RO_WORDS));
    end else begin : g_no_ro
      assign ro_err = 1'b0;
    end
  endgenerate

  assign req_err = range_err | align_err | ro_err;

  assign setup     = (state == IDLE) & PSEL_i;
  assign wait_step = (state == ACCESS) & PSEL_i & PENABLE_i & (cnt != '0);
  assign ready     = (state == ACCESS) & PSEL_i & PENABLE_i & (cnt == '0);
  assign do_write  = ready & write_q & ~err_q;

  // State register.
  always_ff @(posedge PCLK or negedge PPRESETn) begin
    if (!PPRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: setup enters ACCESS; completion or abort returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (PSEL_i) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (!PSEL_i || ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture transfer context at setup and count down wait states in ACCESS.
  always_ff @(posedge PCLK or negedge PPRESETn) begin
    if (!PPRESETn) begin
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      cnt     <= '0;
      rdata_q <= '0;
    end else if (setup) begin
      idx_q   <= idx_lo;
      write_q <= PWRITE_i;
      err_q   <= req_err;
      // Errored transfers complete without wait states.
      cnt     <= req_err ? 4'd0 : 4'(WAIT_STATES);
      rdata_q <= req_err ? '0 : mem[idx_lo];
    end else if (wait_step) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Storage: cleared on reset, byte-lane updates only on a clean write completion.
  always_ff @(posedge PCLK or negedge PPRESETn) begin
    if (!PPRESETn) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_write) begin
      for (int k = 0; k < BYTES; k++) begin
        if (PSTRB_i[k]) begin
          mem[idx_q][8*k +: 8] <= PWDATA_i[8*k +: 8];
        end
      end
    end
  end

  assign PREADY_o  = ready;
  assign PSLVERR_o = ready & err_q;
  assign PRDATA_o  = (ready & ~write_q & ~err_q) ? rdata_q : '0;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave with DATA_WIDTH=32, MEM_DEPTH=16,
// WAIT_STATES=2, RO_WORDS=2. A vector table covers the main read/write/error
// traffic; abort, reset and back-to-back sequences are written out by hand.
module tb_apb_mem_slave;

  localparam int AW = 32;
  localparam int DW = 32;

  // Clock / reset
  logic          pclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic          pwrite = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [DW-1:0] pwdata = '0;
  logic [3:0]    pstrb = '0;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;

  always #5 pclk = ~pclk;

  apb_mem_slave #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MEM_DEPTH  (16),
    .WAIT_STATES(2),
    .RO_WORDS   (2)
  ) dut (
    .PCLK     (pclk),
    .PPRESETn (rst_n),
    .PSEL_i   (psel),
    .PENABLE_i(penable),
    .PWRITE_i (pwrite),
    .PADDR_i  (paddr),
    .PWDATA_i (pwdata),
    .PSTRB_i  (pstrb),
    .PREADY_o (pready),
    .PRDATA_o (prdata),
    .PSLVERR_o(pslverr)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    strb;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_cycles;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  // Scoreboard compare
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Driver: one APB transfer. Entered and left 1ns after a rising edge.
  // cycles counts setup plus access cycles up to and including completion.
  task automatic apb_xfer(input string name, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [3:0] strb, input logic keep_sel,
                          output logic [DW-1:0] rdata, output logic err, output int cycles);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    pstrb   = strb;
    rdata   = '0;
    err     = 1'b0;
    @(negedge pclk);
    check({name, "_setup_ready"}, {31'b0, pready}, 32'd0);
    @(posedge pclk);
    #1;
    penable = 1'b1;
    cycles  = 1;
    forever begin
      @(negedge pclk);
      cycles++;
      if (pready) begin
        rdata = prdata;
        err   = pslverr;
        break;
      end
      check({name, "_wait_err"}, {31'b0, pslverr}, 32'd0);
      check({name, "_wait_rdata"}, prdata, 32'd0);
      if (cycles > 20) begin
        check({name, "_timeout"}, 32'd1, 32'd0);
        break;
      end
      @(posedge pclk);
      #1;
    end
    @(posedge pclk);
    #1;
    penable = 1'b0;
    if (!keep_sel) psel = 1'b0;
  endtask

  task automatic run_vec(input string name, input vec_t v);
    logic [DW-1:0] rd;
    logic          er;
    int            cyc;
    apb_xfer(name, v.wr, v.addr, v.wdata, v.strb, 1'b0, rd, er, cyc);
    check({name, "_rdata"}, rd, v.exp_rdata);
    check({name, "_slverr"}, {31'b0, er}, {31'b0, v.exp_err});
    check({name, "_cycles"}, 32'(cyc), 32'(v.exp_cycles));
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic          er;
    int            c1;
    int            c2;

    //            wr    addr    wdata         strb   exp_rdata     err  cyc
    vecs[0]  = '{1'b0, 32'h08, 32'h0,         4'h0, 32'h00000000, 1'b0, 4};
    vecs[1]  = '{1'b1, 32'h08, 32'hDEADBEEF,  4'hF, 32'h00000000, 1'b0, 4};
    vecs[2]  = '{1'b0, 32'h08, 32'h0,         4'h0, 32'hDEADBEEF, 1'b0, 4};
    vecs[3]  = '{1'b1, 32'h08, 32'h11223344,  4'h5, 32'h00000000, 1'b0, 4};
    vecs[4]  = '{1'b0, 32'h08, 32'h0,         4'h0, 32'hDE22BE44, 1'b0, 4};
    vecs[5]  = '{1'b0, 32'h40, 32'h0,         4'h0, 32'h00000000, 1'b1, 2};
    vecs[6]  = '{1'b1, 32'h0A, 32'hFFFFFFFF,  4'hF, 32'h00000000, 1'b1, 2};
    vecs[7]  = '{1'b1, 32'h04, 32'hFFFFFFFF,  4'hF, 32'h00000000, 1'b1, 2};
    vecs[8]  = '{1'b0, 32'h08, 32'h0,         4'h0, 32'hDE22BE44, 1'b0, 4};
    vecs[9]  = '{1'b0, 32'h04, 32'h0,         4'h0, 32'h00000000, 1'b0, 4};
    vecs[10] = '{1'b1, 32'h14, 32'h55555555,  4'h0, 32'h00000000, 1'b0, 4};
    vecs[11] = '{1'b0, 32'h14, 32'h0,         4'h0, 32'h00000000, 1'b0, 4};
    vecs[12] = '{1'b0, 32'h1000_0008, 32'h0,  4'h0, 32'h00000000, 1'b1, 2};
    vecs[13] = '{1'b1, 32'h20, 32'hCAFEF00D,  4'hA, 32'h00000000, 1'b0, 4};

    // Reset: outputs must be idle even with a select presented.
    psel    = 1'b1;
    penable = 1'b1;
    #2;
    check("rst_ready", {31'b0, pready}, 32'd0);
    check("rst_rdata", prdata, 32'd0);
    check("rst_slverr", {31'b0, pslverr}, 32'd0);
    psel    = 1'b0;
    penable = 1'b0;
    @(posedge pclk);
    @(posedge pclk);
    #1;
    rst_n = 1'b1;
    @(posedge pclk);
    #1;

    for (int i = 0; i < NV; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end
    // Partial-strobe write to 0x20 landed only in lanes 1 and 3.
    apb_xfer("rd20", 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rd, er, c1);
    check("rd20_rdata", rd, 32'hCA00F000);

    // Abort: drop PSEL in the second wait cycle of a write to 0x0C.
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h0C;
    pwdata  = 32'h12345678;
    pstrb   = 4'hF;
    @(posedge pclk);
    #1;
    penable = 1'b1;
    @(negedge pclk);
    check("abort_wait1_ready", {31'b0, pready}, 32'd0);
    @(posedge pclk);
    #1;
    psel    = 1'b0;
    penable = 1'b0;
    @(negedge pclk);
    check("abort_wait2_ready", {31'b0, pready}, 32'd0);
    @(posedge pclk);
    #1;
    apb_xfer("abort_rd0c", 1'b0, 32'h0C, 32'h0, 4'h0, 1'b0, rd, er, c1);
    check("abort_rd0c_rdata", rd, 32'h00000000);
    check("abort_rd0c_cycles", 32'(c1), 32'd4);

    // Reset in the middle of a write wait to 0x10.
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h10;
    pwdata  = 32'hCAFEF00D;
    pstrb   = 4'hF;
    @(posedge pclk);
    #1;
    penable = 1'b1;
    @(negedge pclk);
    check("midrst_wait_ready", {31'b0, pready}, 32'd0);
    @(posedge pclk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'b0, pready}, 32'd0);
    check("midrst_rdata", prdata, 32'd0);
    check("midrst_slverr", {31'b0, pslverr}, 32'd0);
    @(posedge pclk);
    #1;
    psel    = 1'b0;
    penable = 1'b0;
    @(posedge pclk);
    #1;
    rst_n = 1'b1;
    @(posedge pclk);
    #1;
    apb_xfer("postrst_rd08", 1'b0, 32'h08, 32'h0, 4'h0, 1'b0, rd, er, c1);
    check("postrst_rd08_rdata", rd, 32'h00000000);
    apb_xfer("postrst_rd10", 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, er, c1);
    check("postrst_rd10_rdata", rd, 32'h00000000);

    // Back-to-back write then read of 0x3C with PSEL held between them.
    apb_xfer("b2b_wr", 1'b1, 32'h3C, 32'hA5A5A5A5, 4'hF, 1'b1, rd, er, c1);
    apb_xfer("b2b_rd", 1'b0, 32'h3C, 32'h0, 4'h0, 1'b0, rd, er, c2);
    check("b2b_rdata", rd, 32'hA5A5A5A5);
    check("b2b_slverr", {31'b0, er}, 32'd0);
    check("b2b_cycles", 32'(c1 + c2), 32'd8);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
